// File: rtl/uart_fifo_pkg.sv
// Shared constants and the status-register view of the UART TX/RX FIFOs.
package uart_fifo_pkg;

    localparam int UART_FIFO_DEPTH_DEF = 16;
    localparam int UART_FIFO_DW_DEF    = 8;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } uart_fifo_status_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module uart_fifo_ram
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = UART_FIFO_DW_DEF,
    parameter int DEPTH      = UART_FIFO_DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Parametrised UART TX/RX FIFO: pointers, occupancy count, level and sticky error flags.
// Define UART_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module uart_fifo_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = UART_FIFO_DW_DEF,
    parameter int DEPTH      = UART_FIFO_DEPTH_DEF,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

    localparam uart_fifo_status_t STAT_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_nxt;
    uart_fifo_status_t     stat_q;
    uart_fifo_status_t     stat_nxt;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [DATA_WIDTH-1:0] head;

    uart_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (head)
    );

    // A full FIFO still takes a write when a read frees the head slot in the same cycle.
    always_comb begin
        rd_acc    = rd_en & ~stat_q.empty;
        wr_acc    = wr_en & (~stat_q.full | rd_acc);
        count_nxt = count_q;
        if (wr_acc && !rd_acc) begin
            count_nxt = count_q + ONE;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count_q - ONE;
        end
        stat_nxt              = stat_q;
        stat_nxt.full         = (count_nxt == DEPTH_C);
        stat_nxt.empty        = (count_nxt == '0);
        stat_nxt.almost_full  = (count_nxt >= AF_C);
        stat_nxt.almost_empty = (count_nxt <= AE_C);
        stat_nxt.overflow     = (wr_en & ~wr_acc) | (stat_q.overflow & ~err_clr);
        stat_nxt.underflow    = (rd_en & ~rd_acc) | (stat_q.underflow & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            stat_q  <= STAT_RST;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE;
            end
            count_q <= count_nxt;
            stat_q  <= stat_nxt;
        end
    end

`ifdef UART_FIFO_FWFT_EN
    assign rd_data  = stat_q.empty ? '0 : head;
    assign rd_valid = ~stat_q.empty;
`else
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= head;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign count        = count_q;
    assign full         = stat_q.full;
    assign empty        = stat_q.empty;
    assign almost_full  = stat_q.almost_full;
    assign almost_empty = stat_q.almost_empty;
    assign overflow     = stat_q.overflow;
    assign underflow    = stat_q.underflow;

    // The wrap-bit pointer distance must always agree with the separately kept count.
    a_ptr_count: assert property (@(posedge clk) disable iff (!reset_n)
        (wr_ptr - rd_ptr) == count_q);

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl (DEPTH=8, DATA_WIDTH=8); follows UART_FIFO_FWFT_EN if defined.
module tb_uart_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int vectors = 0;
    int miscompares = 0;

    uart_fifo_ctrl #(
        .DATA_WIDTH (8),
        .DEPTH      (8),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // FWFT data is observed before the pop; registered data after it.
    task automatic pop(output logic [7:0] d, output logic v);
`ifdef UART_FIFO_FWFT_EN
        d = rd_data;
        v = rd_valid;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
`else
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        d = rd_data;
        v = rd_valid;
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty: got %b expected 1", empty); end
        vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("FAIL rst_ae: got %b expected 1", almost_empty); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL rst_count: got %0d expected 0", count); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rd_valid: got %b expected 0", rd_valid); end
        vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL rst_rd_data: got %h expected 00", rd_data); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL rst_full: got %b expected 0", full); end
        vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL rst_af: got %b expected 0", almost_full); end
        vectors++; if ({overflow, underflow} !== 2'b00) begin miscompares++; $display("FAIL rst_err: got %b expected 00", {overflow, underflow}); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL empty_rd_underflow: got %b expected 1", underflow); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL empty_rd_count: got %0d expected 0", count); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL empty_rd_valid: got %b expected 0", rd_valid); end
        tick();
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_sticky: got %b expected 1", underflow); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL underflow_clr: got %b expected 0", underflow); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            push(8'(i));
            vectors++; if (count !== 4'(i)) begin miscompares++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i); end
            vectors++; if (almost_full !== (i >= 6)) begin miscompares++; $display("FAIL fill_af[%0d]: got %b expected %b", i, almost_full, (i >= 6)); end
            vectors++; if (almost_empty !== (i <= 2)) begin miscompares++; $display("FAIL fill_ae[%0d]: got %b expected %b", i, almost_empty, (i <= 2)); end
            vectors++; if (full !== (i == 8)) begin miscompares++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 8)); end
            vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL fill_empty[%0d]: got %b expected 0", i, empty); end
        end
        push(8'hFF);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL ovf_count: got %0d expected 8", count); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got %b expected 1", full); end
    endtask

    task automatic test_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        err_clr = 1'b1;
        tick();
        wr_en   = 1'b0;
        err_clr = 1'b0;
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL ovf_set_wins_count: got %0d expected 8", count); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr2: got %b expected 0", overflow); end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_q [9];
        logic [7:0] d;
        logic       v;
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA, 8'h00};
`ifdef UART_FIFO_FWFT_EN
        vectors++; if (rd_data !== 8'h01) begin miscompares++; $display("FAIL full_rw_head: got %h expected 01", rd_data); end
`endif
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        tick();
        rd_en   = 1'b0;
        wr_en   = 1'b0;
`ifndef UART_FIFO_FWFT_EN
        vectors++; if (rd_data !== 8'h01) begin miscompares++; $display("FAIL full_rw_data: got %h expected 01", rd_data); end
        vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL full_rw_valid: got %b expected 1", rd_valid); end
`endif
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL full_rw_count: got %0d expected 8", count); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_rw_full: got %b expected 1", full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_rw_ovf: got %b expected 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            pop(d, v);
            vectors++; if (d !== exp_q[i]) begin miscompares++; $display("FAIL drain_data[%0d]: got %h expected %h", i, d, exp_q[i]); end
            vectors++; if (v !== 1'b1) begin miscompares++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, v); end
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b expected 1", empty); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL drain_count: got %0d expected 0", count); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL drain_underflow: got %b expected 0", underflow); end
    endtask

    task automatic test_empty_rw();
        logic [7:0] d;
        logic       v;
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        tick();
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL empty_rw_count: got %0d expected 1", count); end
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL empty_rw_underflow: got %b expected 1", underflow); end
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL empty_rw_empty: got %b expected 0", empty); end
`ifdef UART_FIFO_FWFT_EN
        vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL empty_rw_valid: got %b expected 1", rd_valid); end
`else
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL empty_rw_valid: got %b expected 0", rd_valid); end
`endif
        pop(d, v);
        vectors++; if (d !== 8'h5A) begin miscompares++; $display("FAIL empty_rw_data: got %h expected 5a", d); end
        vectors++; if (v !== 1'b1) begin miscompares++; $display("FAIL empty_rw_pop_valid: got %b expected 1", v); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL empty_rw_final_count: got %0d expected 0", count); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL empty_rw_clr: got %b expected 0", underflow); end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        logic       v;
        logic       exp_v_idle;
`ifdef UART_FIFO_FWFT_EN
        exp_v_idle = 1'b1;
`else
        exp_v_idle = 1'b0;
`endif
        for (int k = 0; k < 20; k++) begin
            push(8'(8'h30 + k));
            vectors++; if (rd_valid !== exp_v_idle) begin miscompares++; $display("FAIL wrap_valid_after_push[%0d]: got %b expected %b", k, rd_valid, exp_v_idle); end
            pop(d, v);
            vectors++; if (d !== 8'(8'h30 + k)) begin miscompares++; $display("FAIL wrap_data[%0d]: got %h expected %h", k, d, 8'(8'h30 + k)); end
            vectors++; if (v !== 1'b1) begin miscompares++; $display("FAIL wrap_pop_valid[%0d]: got %b expected 1", k, v); end
        end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL wrap_count: got %0d expected 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty: got %b expected 1", empty); end
        tick();
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_idle_valid: got %b expected 0", rd_valid); end
`ifdef UART_FIFO_FWFT_EN
        vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL wrap_idle_data: got %h expected 00", rd_data); end
`else
        vectors++; if (rd_data !== 8'h43) begin miscompares++; $display("FAIL wrap_idle_data: got %h expected 43", rd_data); end
`endif
    endtask

    task automatic test_async_reset();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        vectors++; if (count !== 4'd3) begin miscompares++; $display("FAIL arst_pre_count: got %0d expected 3", count); end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL arst_count: got %0d expected 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL arst_empty: got %b expected 1", empty); end
        vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL arst_rd_data: got %h expected 00", rd_data); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL arst_post_empty: got %b expected 1", empty); end
        vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("FAIL arst_post_ae: got %b expected 1", almost_empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_err_clr();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_fifo_ctrl.md
# uart_fifo_ctrl

Parametrised synchronous FIFO used as the TX and RX buffer between the UART register interface and the serialiser/deserialiser. It generalises the byte-wide UART buffer:
- configurable data width and power-of-two depth;
- occupancy count and programmable almost-full/almost-empty flags;
- sticky overflow/underflow error flags with explicit clear;
- registered or first-word-fall-through (FWFT) read, selected at compile time.

One instance per direction; all outputs are driven from registers, with no combinational path from inputs to outputs.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one FIFO entry in bits.
- DEPTH, 16, number of entries; must be a power of two and ≥ 2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- ADDR_WIDTH, $clog2(DEPTH), derived; do not override.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read (pop) request.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data qualifier (meaning depends on mode; see Configuration).
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- err_clr  in  1  synchronous clear of overflow and underflow.

## Operation
- Pointers: wr_ptr and rd_ptr are each ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address storage; the MSB is the wrap bit. Pointers increment modulo 2^(ADDR_WIDTH+1).
- count is a separate register: +1 on write-only, -1 on read-only, unchanged when both or neither are accepted.
- Read accepted (rd_acc) = rd_en & ~empty.
- Write accepted (wr_acc) = wr_en & (~full | rd_acc). A full FIFO with a simultaneous read and write accepts both, and count stays at DEPTH.
- Empty FIFO with rd_en & wr_en: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
- A rejected write leaves storage and pointers untouched and sets overflow. A rejected read leaves rd_data/rd_ptr untouched and sets underflow.
- overflow/underflow stay set until err_clr. If set and clear occur in the same cycle, set wins.
- Storage is not reset. Only pointers, count, flags, rd_data and rd_valid are reset.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, count = 0, empty = 1, full = 0, almost_full = 0, almost_empty = 1 (if AE_LEVEL ≥ 0), overflow = 0, underflow = 0.
- Reset mid-operation clears all state immediately (asynchronous). Contents are discarded.
- A write at edge N updates count and all flags after edge N.
- Write-to-read latency: data written at edge N is poppable (registered mode) or visible on rd_data (FWFT) from edge N onward, i.e. one cycle after wr_en is presented.
- Registered mode: a read accepted at edge N puts data on rd_data and pulses rd_valid for one cycle after edge N. rd_data holds its last value otherwise.

## Configuration
- Macro: UART_FIFO_FWFT_EN.
- Defined (FWFT mode):
  - rd_data always shows the head entry and rd_valid = ~empty.
  - rd_en pops the head; the next entry appears in the following cycle.
  - rd_data is forced to 0 while empty.
- Undefined (registered mode, default): behaviour as in Timing. rd_valid is a one-cycle pulse per accepted read.
- Pointer, count and flag behaviour is identical in both modes.

## Structure
- Package uart_fifo_pkg holds:
  - default parameter constants UART_FIFO_DEPTH_DEF and UART_FIFO_DW_DEF;
  - typedef uart_fifo_status_t, a packed struct {full, empty, almost_full, almost_empty, overflow, underflow} used by the UART status register.
- Sub-module uart_fifo_ram: DEPTH×DATA_WIDTH storage with one synchronous write port and one asynchronous read port.
- Control (pointers, count, flags, read register) lives in uart_fifo_ctrl.

## Test plan
- Reset with DEPTH=8, DW=8 -> empty=1, almost_empty=1, count=0, rd_valid=0, rd_data=0; then rd_en with no write -> underflow=1, count stays 0.
- Write 0x01..0x08 -> full=1, count=8, almost_full asserts at count=6. A 9th write of 0xFF -> overflow=1, and a later read returns 0x01 (not 0xFF).
- From full, assert rd_en & wr_en with 0xAA -> count stays 8 and no overflow. Eight subsequent reads return 0x02..0x08 then 0xAA.
- Empty FIFO, rd_en & wr_en with 0x5A -> count=1, underflow=1; next read returns 0x5A.
- Error clearing: err_clr while overflow=1 -> overflow cleared next cycle. err_clr in the same cycle as a rejected write -> overflow remains 1.
- Wrap-around: 20 write/read pairs through DEPTH=8 with incrementing data -> in-order data; count returns to 0; empty=1. Run once with UART_FIFO_FWFT_EN (rd_data valid with no rd_en) and once without (1-cycle rd_valid pulses).
